// File: rtl/rcu_pll_pkg.sv
// Shared types and helpers for the RCU core-PLL sequencer.
package rcu_pll_pkg;

    localparam int RCU_CORE_CFG_WIDTH = 3;

    typedef enum logic [2:0] {
        IDLE,
        GATE,
        LOAD,
        WAIT_LOCK,
        SETTLE,
        ERR
    } pll_state_e;

    // Width of a down-counter able to hold the largest of three cycle counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rcu_pll_seq_if.sv
// Config request handshake between a requester and the PLL sequencer.
interface rcu_pll_seq_if;
    import rcu_pll_pkg::*;

    logic                          cfg_req;
    logic [RCU_CORE_CFG_WIDTH-1:0] cfg;
    logic                          cfg_ack;

    modport master (output cfg_req, output cfg, input cfg_ack);
    modport slave  (input cfg_req, input cfg, output cfg_ack);
endinterface

// File: rtl/rcu_lock_sync.sv
// Two-flop synchroniser for asynchronous status inputs; clears to 0 on reset.
module rcu_lock_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    // Two register stages; the first may go metastable, the second is clean.
    always_ff @(posedge clk) begin
        if (srst) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= raw;
            sync_reg <= meta_reg;
        end
    end

    assign synced = sync_reg;

endmodule

// File: rtl/rcu_pll_seq.sv
// RCU core-PLL sequencer: gates the PLL, loads a new core config code,
// re-enables, waits for a synchronised lock, lets it settle, then strobes.
// Also relocks after lock loss and flags a sticky lock timeout.
module rcu_pll_seq
    import rcu_pll_pkg::*;
#(
    parameter int                            OFF_CYCLES    = 16,
    parameter int                            LOCK_TIMEOUT  = 4096,
    parameter int                            SETTLE_CYCLES = 8,
    parameter logic [RCU_CORE_CFG_WIDTH-1:0] RESET_CFG     = 3'd0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    rcu_pll_seq_if.slave                  cfg_bus,
    input  logic                          pll_lock_i,
    output logic                          pll_en_o,
    output logic [RCU_CORE_CFG_WIDTH-1:0] core_cfg_o,
    output logic                          pll_strb_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o
);

    localparam int CW = cnt_width(OFF_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);

    // pll_en_o stays low for GATE plus the single LOAD cycle, so GATE
    // lasts OFF_CYCLES-1 cycles (at least one).
    localparam logic [CW-1:0] GATE_LOAD   = (OFF_CYCLES >= 2) ? CW'(OFF_CYCLES - 2) : '0;
    // The WAIT_LOCK cycle that first sees lock counts as the first settle
    // sample, so SETTLE itself holds SETTLE_CYCLES-1 more samples.
    localparam logic [CW-1:0] SETTLE_LOAD = (SETTLE_CYCLES >= 2) ? CW'(SETTLE_CYCLES - 2) : '0;
    localparam logic [CW-1:0] TMO_LOAD    = CW'(LOCK_TIMEOUT - 1);

    pll_state_e                    state_reg;
    logic [CW-1:0]                 cnt_reg;
    logic [CW-1:0]                 tmo_reg;
    logic [RCU_CORE_CFG_WIDTH-1:0] pend_cfg_reg;
    logic                          ack_reg;
    logic                          lock_s;

    rcu_lock_sync #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk    (clk_i),
        .srst   (rst_i),
        .raw    (pll_lock_i),
        .synced (lock_s)
    );

    assign cfg_bus.cfg_ack = ack_reg;

    // Sequencer FSM; every output is registered as the value for the state being entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= LOAD;
            cnt_reg      <= '0;
            tmo_reg      <= TMO_LOAD;
            pend_cfg_reg <= RESET_CFG;
            ack_reg      <= 1'b0;
            pll_en_o     <= 1'b0;
            core_cfg_o   <= RESET_CFG;
            pll_strb_o   <= 1'b0;
            busy_o       <= 1'b1;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // A request seen with ack high must be honoured, so it
                    // wins over a lock loss arriving in the same cycle.
                    if (cfg_bus.cfg_req && ack_reg) begin
                        if (cfg_bus.cfg == core_cfg_o && pll_strb_o) begin
                            done_o <= 1'b1;
                        end else begin
                            pend_cfg_reg <= cfg_bus.cfg;
                            cnt_reg      <= GATE_LOAD;
                            state_reg    <= GATE;
                            pll_en_o     <= 1'b0;
                            pll_strb_o   <= 1'b0;
                            ack_reg      <= 1'b0;
                            busy_o       <= 1'b1;
                        end
                    end else if (!lock_s) begin
                        tmo_reg    <= TMO_LOAD;
                        state_reg  <= WAIT_LOCK;
                        pll_strb_o <= 1'b0;
                        ack_reg    <= 1'b0;
                        busy_o     <= 1'b1;
                    end
                end
                GATE: begin
                    if (cnt_reg == '0) begin
                        // Present the new code for the whole LOAD cycle.
                        core_cfg_o <= pend_cfg_reg;
                        state_reg  <= LOAD;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                LOAD: begin
                    core_cfg_o <= pend_cfg_reg;
                    tmo_reg    <= TMO_LOAD;
                    pll_en_o   <= 1'b1;
                    state_reg  <= WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (tmo_reg != '0) tmo_reg <= tmo_reg - CW'(1);
                    if (lock_s) begin
                        cnt_reg   <= SETTLE_LOAD;
                        state_reg <= SETTLE;
                    end else if (tmo_reg == '0) begin
                        state_reg <= ERR;
                        pll_en_o  <= 1'b0;
                        err_o     <= 1'b1;
                        ack_reg   <= 1'b1;
                        busy_o    <= 1'b0;
                    end
                end
                SETTLE: begin
                    // Timeout keeps running so lock glitches cannot stretch it.
                    if (tmo_reg != '0) tmo_reg <= tmo_reg - CW'(1);
                    if (!lock_s) begin
                        state_reg <= WAIT_LOCK;
                    end else if (cnt_reg == '0) begin
                        state_reg  <= IDLE;
                        pll_strb_o <= 1'b1;
                        done_o     <= 1'b1;
                        ack_reg    <= 1'b1;
                        busy_o     <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                ERR: begin
                    // Recovery always reapplies the code, even if unchanged.
                    if (cfg_bus.cfg_req && ack_reg) begin
                        pend_cfg_reg <= cfg_bus.cfg;
                        cnt_reg      <= GATE_LOAD;
                        state_reg    <= GATE;
                        err_o        <= 1'b0;
                        ack_reg      <= 1'b0;
                        busy_o       <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= LOAD;
                    pll_en_o  <= 1'b0;
                    ack_reg   <= 1'b0;
                    busy_o    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rcu_pll_seq.sv
// Self-checking bench for rcu_pll_seq with a transaction-level timing model.
module tb_rcu_pll_seq;
    import rcu_pll_pkg::*;

    localparam int OFF_CYCLES    = 16;
    localparam int LOCK_TIMEOUT  = 4096;
    localparam int SETTLE_CYCLES = 8;
    localparam int SYNC_STAGES   = 2;
    localparam int STRB_LATENCY  = SYNC_STAGES + SETTLE_CYCLES;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_en;
    logic [2:0] core_cfg;
    logic       pll_strb;
    logic       busy;
    logic       done;
    logic       err;

    int         n_run = 0;
    int         n_fail = 0;
    logic [2:0] cur_cfg;

    rcu_pll_seq_if bus ();

    rcu_pll_seq #(
        .OFF_CYCLES    (OFF_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .RESET_CFG     (3'd0)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg_bus    (bus.slave),
        .pll_lock_i (pll_lock),
        .pll_en_o   (pll_en),
        .core_cfg_o (core_cfg),
        .pll_strb_o (pll_strb),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] pick_code(input logic [2:0] avoid);
        logic [2:0] c;
        do c = 3'($urandom_range(7, 0)); while (c == avoid || c == 3'd2);
        return c;
    endfunction

    // Issue a request from IDLE/ERR and walk the PLL-off window up to WAIT_LOCK.
    task automatic start_seq(input logic [2:0] code, input string tag);
        int n;
        bit held_acked;
        logic [2:0] first_cfg, last_cfg, old_cfg;
        old_cfg = cur_cfg;
        bus.cfg = code;
        bus.cfg_req = 1'b1;
        n_run++;
        if (bus.cfg_ack !== 1'b1) begin
            $display("FAIL %s_ack_ready: got %b want 1", tag, bus.cfg_ack); n_fail++;
        end
        tick();
        bus.cfg = code + 3'd1;
        n_run++;
        if ({bus.cfg_ack, busy, pll_en, pll_strb, done, err} !== 6'b010000) begin
            $display("FAIL %s_accept {ack,busy,en,strb,done,err}: got %b want 010000", tag,
                     {bus.cfg_ack, busy, pll_en, pll_strb, done, err}); n_fail++;
        end
        pll_lock = 1'b0;
        n = 0;
        held_acked = 0;
        first_cfg = core_cfg;
        last_cfg = core_cfg;
        while (pll_en === 1'b0 && n < OFF_CYCLES + 20) begin
            if (bus.cfg_ack === 1'b1) held_acked = 1;
            last_cfg = core_cfg;
            n++;
            tick();
        end
        if (bus.cfg_ack === 1'b1) held_acked = 1;
        bus.cfg_req = 1'b0;
        n_run++;
        if (n != OFF_CYCLES) begin
            $display("FAIL %s_off_cycles: got %0d want %0d", tag, n, OFF_CYCLES); n_fail++;
        end
        n_run++;
        if (first_cfg !== old_cfg) begin
            $display("FAIL %s_cfg_early: got %0d want %0d", tag, first_cfg, old_cfg); n_fail++;
        end
        n_run++;
        if (last_cfg !== code || core_cfg !== code) begin
            $display("FAIL %s_cfg_load: got %0d/%0d want %0d", tag, last_cfg, core_cfg, code); n_fail++;
        end
        n_run++;
        if (held_acked) begin
            $display("FAIL %s_held_req: got ack=1 while busy want 0", tag); n_fail++;
        end
        cur_cfg = code;
        $display("[TB] %s: request cfg=%0d accepted, pll off %0d cycles", tag, code, n);
    endtask

    // Model PLL raises lock 'delay' cycles after pll_en rose; expect strobe after sync+settle.
    task automatic lock_after(input int delay, input string tag);
        int n;
        bit bad_wait, early_done;
        bad_wait = 0;
        early_done = 0;
        repeat (delay) begin
            tick();
            if (pll_en !== 1'b1 || pll_strb !== 1'b0 || busy !== 1'b1) bad_wait = 1;
        end
        pll_lock = 1'b1;
        n = 0;
        while (pll_strb !== 1'b1 && n < STRB_LATENCY + 20) begin
            tick();
            n++;
            if (done === 1'b1 && pll_strb !== 1'b1) early_done = 1;
        end
        n_run++;
        if (bad_wait) begin
            $display("FAIL %s_wait: got en/strb/busy disturbed want 1/0/1", tag); n_fail++;
        end
        n_run++;
        if (n != STRB_LATENCY) begin
            $display("FAIL %s_strb_latency: got %0d want %0d", tag, n, STRB_LATENCY); n_fail++;
        end
        n_run++;
        if (done !== 1'b1 || early_done) begin
            $display("FAIL %s_done: got %b (early=%0d) want 1 with strobe", tag, done, early_done); n_fail++;
        end
        n_run++;
        if (core_cfg !== cur_cfg || err !== 1'b0) begin
            $display("FAIL %s_cfg_err: got cfg=%0d err=%b want cfg=%0d err=0", tag, core_cfg, err, cur_cfg); n_fail++;
        end
        tick();
        n_run++;
        if ({done, busy, bus.cfg_ack, pll_en} !== 4'b0011) begin
            $display("FAIL %s_idle {done,busy,ack,en}: got %b want 0011", tag,
                     {done, busy, bus.cfg_ack, pll_en}); n_fail++;
        end
        $display("[TB] %s: cfg=%0d strobe %0d cycles after lock", tag, core_cfg, n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_run++;
        if ({pll_en, core_cfg, pll_strb, busy, bus.cfg_ack, done, err} !== 9'b0_000_0_1_0_0_0) begin
            $display("FAIL reset_values: got %b want 000001000",
                     {pll_en, core_cfg, pll_strb, busy, bus.cfg_ack, done, err}); n_fail++;
        end
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_boot(input string tag);
        rst = 1'b0;
        cur_cfg = 3'd0;
        tick();
        n_run++;
        if ({pll_en, core_cfg, busy, bus.cfg_ack} !== 6'b1_000_1_0) begin
            $display("FAIL %s_cycle1 {en,cfg,busy,ack}: got %b want 100010", tag,
                     {pll_en, core_cfg, busy, bus.cfg_ack}); n_fail++;
        end
        lock_after(20, tag);
    endtask

    task automatic test_reconfig();
        start_seq(3'd5, "reconfig");
        lock_after($urandom_range(40, 3), "reconfig");
    endtask

    task automatic test_same_code();
        bit disturbed;
        disturbed = 0;
        bus.cfg = cur_cfg;
        bus.cfg_req = 1'b1;
        n_run++;
        if (bus.cfg_ack !== 1'b1) begin
            $display("FAIL same_ack: got %b want 1", bus.cfg_ack); n_fail++;
        end
        tick();
        bus.cfg_req = 1'b0;
        n_run++;
        if ({done, pll_en, pll_strb, busy} !== 4'b1110) begin
            $display("FAIL same_done {done,en,strb,busy}: got %b want 1110", {done, pll_en, pll_strb, busy}); n_fail++;
        end
        repeat (5) begin
            tick();
            if (pll_en !== 1'b1 || done !== 1'b0 || bus.cfg_ack !== 1'b1 || core_cfg !== cur_cfg) disturbed = 1;
        end
        n_run++;
        if (disturbed) begin
            $display("FAIL same_no_relock: got relock activity want steady IDLE"); n_fail++;
        end
        $display("[TB] same_code: cfg=%0d done without relock", cur_cfg);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            start_seq(pick_code(cur_cfg), "b2b");
            lock_after($urandom_range(60, 1), "b2b");
        end
    endtask

    task automatic test_glitch();
        int n;
        bit bad;
        // One-cycle lock drop in the middle of SETTLE restarts the settle window.
        start_seq(pick_code(cur_cfg), "glitch");
        repeat ($urandom_range(30, 5)) tick();
        pll_lock = 1'b1;
        repeat (5) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        n = 0;
        while (pll_strb !== 1'b1 && n < STRB_LATENCY + 20) begin tick(); n++; end
        n_run++;
        if (n != STRB_LATENCY || done !== 1'b1 || err !== 1'b0) begin
            $display("FAIL glitch_resettle: got lat=%0d done=%b err=%b want %0d/1/0", n, done, err, STRB_LATENCY); n_fail++;
        end
        $display("[TB] glitch: strobe %0d cycles after lock returned", n);
        repeat (3) tick();
        // Lock loss while idle: strobe drops after the synchroniser, relock on its own.
        pll_lock = 1'b0;
        n = 0;
        bad = 0;
        while (pll_strb === 1'b1 && n < 20) begin tick(); n++; end
        n_run++;
        if (n != SYNC_STAGES + 1) begin
            $display("FAIL loss_strb_drop: got %0d want %0d", n, SYNC_STAGES + 1); n_fail++;
        end
        n_run++;
        if ({pll_en, busy, bus.cfg_ack, core_cfg} !== {3'b110, cur_cfg}) begin
            $display("FAIL loss_state {en,busy,ack,cfg}: got %b want %b", {pll_en, busy, bus.cfg_ack, core_cfg},
                     {3'b110, cur_cfg}); n_fail++;
        end
        lock_after($urandom_range(25, 2), "relock");
    endtask

    task automatic test_timeout();
        int n;
        start_seq(3'd2, "timeout");
        n = 0;
        while (pll_en === 1'b1 && n < LOCK_TIMEOUT + 50) begin n++; tick(); end
        n_run++;
        if (n != LOCK_TIMEOUT) begin
            $display("FAIL timeout_cycles: got %0d want %0d", n, LOCK_TIMEOUT); n_fail++;
        end
        n_run++;
        if ({err, bus.cfg_ack, busy, pll_strb, done, pll_en} !== 6'b110000) begin
            $display("FAIL timeout_err {err,ack,busy,strb,done,en}: got %b want 110000",
                     {err, bus.cfg_ack, busy, pll_strb, done, pll_en}); n_fail++;
        end
        $display("[TB] timeout: err after %0d cycles", n);
        start_seq(3'd2, "err_retry");
        lock_after($urandom_range(40, 3), "err_retry");
    endtask

    task automatic test_timeout_budget();
        int n;
        bit strobed;
        start_seq(pick_code(cur_cfg), "budget");
        n = 0;
        strobed = 0;
        while (pll_en === 1'b1 && n < LOCK_TIMEOUT + 50) begin
            if (n == 100) pll_lock = 1'b1;
            if (n == 105) pll_lock = 1'b0;
            if (pll_strb === 1'b1) strobed = 1;
            n++;
            tick();
        end
        n_run++;
        if (n != LOCK_TIMEOUT || err !== 1'b1 || strobed) begin
            $display("FAIL budget_timeout: got cycles=%0d err=%b strobed=%0d want %0d/1/0", n, err, strobed,
                     LOCK_TIMEOUT); n_fail++;
        end
        $display("[TB] budget: err after %0d cycles despite mid-settle lock", n);
    endtask

    task automatic test_reset_mid();
        start_seq(3'd6, "reset_mid");
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n_run++;
        if ({pll_en, core_cfg, pll_strb, busy, bus.cfg_ack, done, err} !== 9'b0_000_0_1_0_0_0) begin
            $display("FAIL reset_mid_values: got %b want 000001000",
                     {pll_en, core_cfg, pll_strb, busy, bus.cfg_ack, done, err}); n_fail++;
        end
        $display("[TB] reset_mid: reset during WAIT_LOCK");
        test_boot("reboot");
    endtask

    initial begin
        bus.cfg_req = 1'b0;
        bus.cfg = 3'd0;
        cur_cfg = 3'd0;
        test_reset();
        test_boot("boot");
        test_reconfig();
        test_same_code();
        test_back_to_back();
        test_glitch();
        test_timeout();
        test_timeout_budget();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
